// File: rtl/ntsc_zbt_pkg.sv
// Shared defaults, state/event types and arithmetic helpers for the NTSC-to-ZBT pixel packer.
package ntsc_zbt_pkg;
   localparam int PIX_W_D        = 18;
   localparam int PIX_PER_WORD_D = 2;
   localparam int MEM_W_D        = 36;
   localparam int ADDR_W_D       = 19;
   localparam int Y_BITS_D       = 9;
   localparam int MAX_X_D        = 1024;
   localparam int MAX_Y_D        = 384;
   localparam int FIFO_DEPTH_D   = 4;
   localparam int XW_BITS        = ADDR_W_D - Y_BITS_D - 1;

   typedef enum logic {ST_WAIT_SOF, ST_ACTIVE} pk_state_t;
   typedef enum logic [1:0] {EV_NONE, EV_SOF, EV_SOL, EV_PIX} pix_ev_t;

   // {y, field, xw}; the caller truncates to the address width, which drops y bits above Y_BITS.
   function automatic logic [31:0] pack_addr(input logic [31:0] y, input logic fld,
                                             input logic [31:0] xw, input int xw_bits);
      logic [31:0] mask;
      mask = (32'd1 << xw_bits) - 32'd1;
      return (y << (xw_bits + 1)) | ({31'd0, fld} << xw_bits) | (xw & mask);
   endfunction

   function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] lim);
      return (v >= lim) ? lim : v + 32'd1;
   endfunction

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction
endpackage

// File: rtl/ntsc_pix_packer_if.sv
// Pixel-stream input and ZBT write-port bundle; the packer sits on the slave modport.
interface ntsc_pix_packer_if import ntsc_zbt_pkg::*; #(
   parameter int PIX_W  = PIX_W_D,
   parameter int MEM_W  = MEM_W_D,
   parameter int ADDR_W = ADDR_W_D
);
   logic              pix_valid;
   logic [PIX_W-1:0]  pix_data;
   logic              pix_sol;
   logic              pix_sof;
   logic              pix_field;
   logic              wr_valid;
   logic              wr_ready;
   logic [ADDR_W-1:0] wr_addr;
   logic [MEM_W-1:0]  wr_data;
   logic [15:0]       ovf_cnt;
   logic              field_start;

   modport master (
      output pix_valid, pix_data, pix_sol, pix_sof, pix_field, wr_ready,
      input  wr_valid, wr_addr, wr_data, ovf_cnt, field_start
   );

   modport slave (
      input  pix_valid, pix_data, pix_sol, pix_sof, pix_field, wr_ready,
      output wr_valid, wr_addr, wr_data, ovf_cnt, field_start
   );
endinterface

// File: rtl/ntsc_word_fifo.sv
// Small synchronous FIFO for packed {addr, data} words; flags are registered and the head is zero while empty.
module ntsc_word_fifo import ntsc_zbt_pkg::*; #(
   parameter int WIDTH = ADDR_W_D + MEM_W_D,
   parameter int DEPTH = FIFO_DEPTH_D
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_wr_en,
   input  logic [WIDTH-1:0] i_wr_data,
   input  logic             i_rd_en,
   output logic [WIDTH-1:0] o_rd_data,
   output logic             o_full,
   output logic             o_empty
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_cnt;
   logic             r_full;
   logic             r_empty;
   logic             w_push;
   logic             w_pop;
   logic [AW:0]      w_cnt_nxt;

   // Fullness is judged before any same-cycle pop, so a write into a full FIFO is always refused.
   always_comb begin
      w_push    = i_wr_en && !r_full;
      w_pop     = i_rd_en && !r_empty;
      w_cnt_nxt = r_cnt;
      if (w_push && !w_pop)
         w_cnt_nxt = r_cnt + 1'b1;
      else if (w_pop && !w_push)
         w_cnt_nxt = r_cnt - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_cnt    <= '0;
         r_full   <= 1'b0;
         r_empty  <= 1'b1;
      end else begin
         if (w_push)
            r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + 1'b1;
         r_cnt   <= w_cnt_nxt;
         r_full  <= (w_cnt_nxt == FULL_CNT);
         r_empty <= (w_cnt_nxt == '0);
      end
   end

   always_ff @(posedge clk) begin
      if (w_push)
         r_mem[r_wr_ptr] <= i_wr_data;
   end

   assign o_rd_data = r_empty ? '0 : r_mem[r_rd_ptr];
   assign o_full    = r_full;
   assign o_empty   = r_empty;
endmodule

// File: rtl/ntsc_pix_packer.sv
// Packs PIX_PER_WORD pixels per ZBT word with an interlace-aware address and queues words for the arbiter.
// Optional crop window enabled by defining NTSC_CROP_EN (origin COL_START/ROW_START).
module ntsc_pix_packer import ntsc_zbt_pkg::*; #(
   parameter int PIX_W        = PIX_W_D,
   parameter int PIX_PER_WORD = PIX_PER_WORD_D,
   parameter int MEM_W        = MEM_W_D,
   parameter int ADDR_W       = ADDR_W_D,
   parameter int Y_BITS       = Y_BITS_D,
   parameter int MAX_X        = MAX_X_D,
   parameter int MAX_Y        = MAX_Y_D,
   parameter int FIFO_DEPTH   = FIFO_DEPTH_D,
   parameter int COL_START    = 0,
   parameter int ROW_START    = 0
) (
   input  logic              clk,
   input  logic              reset,
   ntsc_pix_packer_if.slave  bus
);
   localparam int PW   = PIX_W * PIX_PER_WORD;
   localparam int LW   = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;
   localparam int LSH  = $clog2(PIX_PER_WORD);
   localparam int XWB  = ADDR_W - Y_BITS - 1;
`ifdef NTSC_CROP_EN
   localparam int X_OFS = COL_START;
   localparam int Y_OFS = ROW_START;
`else
   localparam int X_OFS = 0;
   localparam int Y_OFS = 0;
`endif
   localparam int X_LIM = MAX_X + X_OFS;
   localparam int Y_LIM = MAX_Y + Y_OFS;
   localparam int XCW   = $clog2(X_LIM + 1);
   localparam int YCW   = $clog2(Y_LIM + 1);

   pk_state_t          r_state;
   pk_state_t          w_state_nxt;
   pix_ev_t            w_ev;
   logic [XCW-1:0]     r_x;
   logic [YCW-1:0]     r_y;
   logic [LW-1:0]      r_lane;
   logic               r_field;
   logic [PW-1:0]      r_word;
   logic [XWB-1:0]     r_xw0;
   logic               r_vld_p1;
   logic [ADDR_W-1:0]  r_addr_p1;
   logic [MEM_W-1:0]   r_data_p1;
   logic [15:0]        r_ovf;
   logic               r_field_start;

   logic [XCW-1:0]     w_x_cur;
   logic [YCW-1:0]     w_y_cur;
   logic [LW-1:0]      w_lane_cur;
   logic               w_field_cur;
   logic               w_flush;
   logic               w_in_win;
   logic               w_acc;
   logic               w_done;
   logic [XCW-1:0]     w_x_rel;
   logic [YCW-1:0]     w_y_rel;
   logic [YCW-1:0]     w_ry_rel;
   logic [XWB-1:0]     w_xw_cur;
   logic [XWB-1:0]     w_xw0;
   logic [PW-1:0]      w_word_nxt;
   logic               w_full;
   logic               w_empty;
   logic [ADDR_W+MEM_W-1:0] w_fifo_dout;

   // ---- p0: classify the incoming pixel and resolve its position ----
   always_comb begin
      w_ev = EV_NONE;
      if (bus.pix_valid) begin
         if (bus.pix_sof)
            w_ev = EV_SOF;
         else if (r_state == ST_ACTIVE)
            w_ev = bus.pix_sol ? EV_SOL : EV_PIX;
      end
      w_state_nxt = (w_ev == EV_SOF) ? ST_ACTIVE : r_state;

      w_x_cur     = r_x;
      w_y_cur     = r_y;
      w_lane_cur  = r_lane;
      w_field_cur = r_field;
      w_flush     = 1'b0;
      case (w_ev)
         EV_SOF: begin
            w_x_cur     = '0;
            w_y_cur     = '0;
            w_lane_cur  = '0;
            w_field_cur = bus.pix_field;
         end
         EV_SOL: begin
            w_x_cur    = '0;
            w_y_cur    = YCW'(sat_inc(32'(r_y), 32'(Y_LIM)));
            w_lane_cur = '0;
            w_flush    = (r_lane != '0);
         end
         default: ;
      endcase
   end

   always_comb begin
`ifdef NTSC_CROP_EN
      w_in_win = (w_x_cur >= XCW'(X_OFS)) && (w_x_cur < XCW'(X_LIM)) &&
                 (w_y_cur >= YCW'(Y_OFS)) && (w_y_cur < YCW'(Y_LIM));
`else
      w_in_win = (w_x_cur < XCW'(X_LIM)) && (w_y_cur < YCW'(Y_LIM));
`endif
      w_x_rel  = w_x_cur - XCW'(X_OFS);
      w_y_rel  = w_y_cur - YCW'(Y_OFS);
      w_ry_rel = r_y - YCW'(Y_OFS);
      w_xw_cur = XWB'(w_x_rel >> LSH);
      w_acc    = (w_ev != EV_NONE) && w_in_win;
      w_done   = w_acc && (w_lane_cur == LW'(PIX_PER_WORD - 1));
      w_xw0    = (w_lane_cur == '0) ? w_xw_cur : r_xw0;

      // Lane 0 starts a fresh zeroed word, so a later flush carries zeros in the unfilled lanes.
      w_word_nxt = (w_lane_cur == '0) ? '0 : r_word;
      for (int l = 0; l < PIX_PER_WORD; l++) begin
         if (w_lane_cur == LW'(l))
            w_word_nxt[(PIX_PER_WORD-1-l)*PIX_W +: PIX_W] = bus.pix_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= ST_WAIT_SOF;
         r_x           <= '0;
         r_y           <= '0;
         r_lane        <= '0;
         r_field       <= 1'b0;
         r_vld_p1      <= 1'b0;
         r_field_start <= 1'b0;
         r_ovf         <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_ev != EV_NONE) begin
            r_x     <= XCW'(sat_inc(32'(w_x_cur), 32'(X_LIM)));
            r_y     <= w_y_cur;
            r_field <= w_field_cur;
            if (w_done)
               r_lane <= '0;
            else if (w_acc)
               r_lane <= w_lane_cur + 1'b1;
            else
               r_lane <= w_lane_cur;
         end
         r_vld_p1      <= w_done || w_flush;
         r_field_start <= (w_ev == EV_SOF);
         if (r_vld_p1 && w_full)
            r_ovf <= sat_inc16(r_ovf);
      end
   end

   // ---- p1: completed or flushed word waiting for the FIFO write ----
   always_ff @(posedge clk) begin
      if (w_acc) begin
         r_word <= w_word_nxt;
         r_xw0  <= w_xw0;
      end
      if (w_flush) begin
         r_addr_p1 <= ADDR_W'(pack_addr(32'(w_ry_rel), r_field, 32'(r_xw0), XWB));
         r_data_p1 <= MEM_W'(r_word);
      end else begin
         r_addr_p1 <= ADDR_W'(pack_addr(32'(w_y_rel), w_field_cur, 32'(w_xw0), XWB));
         r_data_p1 <= MEM_W'(w_word_nxt);
      end
   end

   // ---- p2: FIFO toward the ZBT arbiter ----
   ntsc_word_fifo #(
      .WIDTH (ADDR_W + MEM_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .i_wr_en   (r_vld_p1),
      .i_wr_data ({r_addr_p1, r_data_p1}),
      .i_rd_en   (bus.wr_ready),
      .o_rd_data (w_fifo_dout),
      .o_full    (w_full),
      .o_empty   (w_empty)
   );

   assign bus.wr_valid    = !w_empty;
   assign bus.wr_addr     = w_fifo_dout[MEM_W +: ADDR_W];
   assign bus.wr_data     = w_fifo_dout[MEM_W-1:0];
   assign bus.ovf_cnt     = r_ovf;
   assign bus.field_start = r_field_start;
endmodule

// File: tb/tb_ntsc_pix_packer.sv
// Scoreboard bench for ntsc_pix_packer: directed pixel streams, expected writes queued, monitor compares pops.
module tb_ntsc_pix_packer;
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   ntsc_pix_packer_if bus ();

   ntsc_pix_packer #(.COL_START(30), .ROW_START(0)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_chk = 0;
   int n_fail = 0;
   logic [54:0] exp_q[$];
   logic [54:0] mon_e;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
      n_chk++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", name, got, want);
      end
   endtask

   task automatic expect_wr(input logic [18:0] a, input logic [35:0] d);
      exp_q.push_back({a, d});
   endtask

   always @(negedge clk) begin
      if (!reset && bus.wr_valid === 1'b1 && bus.wr_ready === 1'b1) begin
         n_chk++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL wr_unexpected: got addr %0h data %0h, required no write", bus.wr_addr, bus.wr_data);
         end else begin
            mon_e = exp_q.pop_front();
            if ({bus.wr_addr, bus.wr_data} !== mon_e) begin
               n_fail++;
               $display("FAIL wr_word: got addr %0h data %0h, required addr %0h data %0h",
                        bus.wr_addr, bus.wr_data, mon_e[54:36], mon_e[35:0]);
            end
         end
      end
   end

   task automatic pix(input logic sof, input logic sol, input logic fld, input logic [17:0] d);
      @(posedge clk); #1;
      bus.pix_valid = 1'b1;
      bus.pix_sof   = sof;
      bus.pix_sol   = sol | sof;
      bus.pix_field = fld;
      bus.pix_data  = d;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
         bus.pix_valid = 1'b0;
         bus.pix_sof   = 1'b0;
         bus.pix_sol   = 1'b0;
      end
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      reset = 1'b1;
      bus.pix_valid = 1'b0;
      bus.pix_sof   = 1'b0;
      bus.pix_sol   = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 3000 && exp_q.size() != 0; i++)
         @(negedge clk);
      n_chk++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL %s_drain: got %0d words still pending, required 0", name, exp_q.size());
         exp_q.delete();
      end
      repeat (4) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got time limit expired, required test completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.pix_valid = 1'b0;
      bus.pix_sof   = 1'b0;
      bus.pix_sol   = 1'b0;
      bus.pix_field = 1'b0;
      bus.pix_data  = '0;
      bus.wr_ready  = 1'b0;
      do_reset();
      @(negedge clk);
      chk("rst_wr_valid", bus.wr_valid, 0);
      chk("rst_wr_addr", bus.wr_addr, 0);
      chk("rst_wr_data", bus.wr_data, 0);
      chk("rst_ovf_cnt", bus.ovf_cnt, 0);
      chk("rst_field_start", bus.field_start, 0);

`ifndef NTSC_CROP_EN
      // Basic packing: A,B -> addr 0, C,D -> addr 1
      bus.wr_ready = 1'b1;
      expect_wr(19'h0, {18'h0000A, 18'h0000B});
      expect_wr(19'h1, {18'h0000C, 18'h0000D});
      pix(1, 1, 0, 18'h0000A);
      pix(0, 0, 0, 18'h0000B);
      @(negedge clk);
      chk("field_start_pulse", bus.field_start, 1);
      pix(0, 0, 0, 18'h0000C);
      @(negedge clk);
      chk("wr_valid_at_k", bus.wr_valid, 0);
      chk("field_start_clear", bus.field_start, 0);
      pix(0, 0, 0, 18'h0000D);
      @(negedge clk);
      chk("wr_valid_at_k1", bus.wr_valid, 1);
      chk("first_addr", bus.wr_addr, 0);
      idle(1);
      drain("basic");

      // Field 1, line flushes with zero fill; trailing partial discarded by sof
      expect_wr(19'h200, {18'h01111, 18'h00000});
      expect_wr(19'h600, {18'h02222, 18'h03333});
      expect_wr(19'h601, {18'h04444, 18'h00000});
      pix(1, 1, 1, 18'h01111);
      pix(0, 1, 0, 18'h02222);
      pix(0, 0, 0, 18'h03333);
      pix(0, 0, 0, 18'h04444);
      pix(0, 1, 0, 18'h05555);
      pix(1, 1, 0, 18'h06666);
      idle(1);
      drain("field1");

      // Back-pressure: 6 words, 4 buffered, 2 dropped
      bus.wr_ready = 1'b0;
      for (int i = 0; i < 4; i++)
         expect_wr(19'(i), {18'(18'h100 + 2*i), 18'(18'h101 + 2*i)});
      for (int i = 0; i < 12; i++)
         pix(i == 0, i == 0, 0, 18'(18'h100 + i));
      idle(6);
      @(negedge clk);
      chk("ovf_two", bus.ovf_cnt, 2);
      chk("full_wr_valid", bus.wr_valid, 1);
      chk("hold_addr", bus.wr_addr, 0);
      chk("hold_data", bus.wr_data, {18'h100, 18'h101});
      idle(2);
      @(negedge clk);
      chk("hold_addr_later", bus.wr_addr, 0);
      bus.wr_ready = 1'b1;
      drain("ovf");

      // Push while full with a same-cycle pop is still dropped
      bus.wr_ready = 1'b0;
      for (int i = 0; i < 4; i++)
         expect_wr(19'(i), {18'(18'h200 + 2*i), 18'(18'h201 + 2*i)});
      expect_wr(19'h5, {18'h20A, 18'h20B});
      for (int i = 0; i < 12; i++) begin
         pix(i == 0, i == 0, 0, 18'(18'h200 + i));
         if (i == 10)
            bus.wr_ready = 1'b1;
      end
      idle(1);
      drain("full_pop");
      chk("ovf_full_pop", bus.ovf_cnt, 3);

      // Long line: x saturates, last word xw=511, next line starts clean at lane 0
      for (int xw = 0; xw < 512; xw++)
         expect_wr(19'(xw), {18'(2*xw), 18'(2*xw + 1)});
      expect_wr(19'h400, {18'h3AAAA, 18'h3BBBB});
      for (int x = 0; x < 1100; x++)
         pix(x == 0, x == 0, 0, 18'(x));
      pix(0, 1, 0, 18'h3AAAA);
      pix(0, 0, 0, 18'h3BBBB);
      idle(1);
      drain("long_line");

      // Reset mid-word discards everything; pixels before sof ignored
      pix(1, 1, 0, 18'h0AAAA);
      do_reset();
      @(negedge clk);
      chk("reset_ovf_clear", bus.ovf_cnt, 0);
      chk("reset_wr_valid", bus.wr_valid, 0);
      pix(0, 0, 0, 18'h0BBBB);
      pix(0, 0, 0, 18'h0CCCC);
      idle(4);
      @(negedge clk);
      chk("no_write_before_sof", bus.wr_valid, 0);
      expect_wr(19'h0, {18'h0DDDD, 18'h0EEEE});
      pix(1, 1, 0, 18'h0DDDD);
      pix(0, 0, 0, 18'h0EEEE);
      idle(1);
      drain("after_reset");
`else
      // Crop at COL_START=30: x=30 lands in lane 0 of addr 0
      bus.wr_ready = 1'b1;
      expect_wr(19'h0, {18'h31E, 18'h31F});
      expect_wr(19'h1, {18'h320, 18'h321});
      for (int x = 0; x < 34; x++)
         pix(x == 0, x == 0, 0, 18'(18'h300 + x));
      idle(1);
      drain("crop");
      chk("crop_ovf", bus.ovf_cnt, 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/ntsc_pix_packer.md
# ntsc_pix_packer

Parametrised successor to the NTSC-to-ZBT write path. Accepts an already clock-synchronised pixel stream from the video decoder front end. Packs `PIX_PER_WORD` pixels into one ZBT word and generates an interlace-aware address in which pixel (0,0) lands in word 0. Buffers completed words in a small FIFO that drains to the ZBT arbiter through a valid/ready handshake, counting any words dropped on overflow.

## Interface
Parameters:
- `PIX_W`, 18: bits per pixel.
- `PIX_PER_WORD`, 2: pixels per memory word; power of 2, 1..4.
- `MEM_W`, 36: memory word width; must satisfy `PIX_W*PIX_PER_WORD <= MEM_W`; unused MSBs are zero.
- `ADDR_W`, 19: ZBT address width.
- `Y_BITS`, 9: row field width in the address.
- `MAX_X`, 1024: pixels per line kept; pixels with x >= `MAX_X` are dropped.
- `MAX_Y`, 384: lines per field kept; lines with y >= `MAX_Y` are dropped.
- `FIFO_DEPTH`, 4: output FIFO entries; power of 2, >= 2.
- `COL_START`, 0: crop origin x; used only with `NTSC_CROP_EN`.
- `ROW_START`, 0: crop origin y; used only with `NTSC_CROP_EN`.

Ports:
- `clk`, in, 1: system clock. Single clock; all logic is on `posedge clk`.
- `reset`, in, 1: synchronous, active-high reset.
- `pix_valid`, in, 1: pixel present this cycle.
- `pix_data`, in, `PIX_W`: pixel value.
- `pix_sol`, in, 1: start of line. Qualified by `pix_valid`; marks the first pixel of a line.
- `pix_sof`, in, 1: start of field. Qualified by `pix_valid`; implies `pix_sol`.
- `pix_field`, in, 1: field parity. Sampled on `pix_sof`.
- `wr_valid`, out, 1: word available.
- `wr_ready`, in, 1: arbiter accepts the word.
- `wr_addr`, out, `ADDR_W`: write address.
- `wr_data`, out, `MEM_W`: write data.
- `ovf_cnt`, out, 16: saturating count of dropped words.
- `field_start`, out, 1: one-cycle pulse on each accepted `pix_sof`.

## Operation
- Counters: x (pixel in line), y (line in field), lane (0..`PIX_PER_WORD`-1), and latched field bit.
- A pixel is accepted when `pix_valid` is high and its (x, y) is inside the limits.
- An accepted pixel is written into lane `lane`. Lane 0 occupies the MS bits of the packed field, so the earliest pixel is highest.
- lane wraps at `PIX_PER_WORD`-1, which completes the word. The word's address is `{y[Y_BITS-1:0], field, xw}`, where xw = x of the lane-0 pixel / `PIX_PER_WORD`, truncated to `ADDR_W-Y_BITS-1` bits.
- `pix_sof`: x←0, y←0, lane←0, field←`pix_field`. Any partial word is discarded, not written. `field_start` pulses.
- `pix_sol` without `pix_sof`: y←y+1, saturating at `MAX_Y`. x←0. If lane≠0, the partial word is flushed with the missing lanes zero-filled. The new pixel goes to lane 0 in the same cycle.
- x saturates at `MAX_X`. Pixels beyond `MAX_X` never advance lane.
- At most one FIFO push per cycle. Flush and completion are mutually exclusive: a flush implies lane≠0, so it cannot coincide with a lane wrap.
- FIFO full at push time: the word is dropped and `ovf_cnt` increments, saturating at 16'hFFFF. Fullness is evaluated before a same-cycle pop, so a push while full with `wr_ready` high is still dropped.
- Pop: `wr_valid && wr_ready`. `wr_addr`/`wr_data` are stable while `wr_valid` is high and `wr_ready` is low.

## Timing
- Pixel accepted at edge k completes the word. The FIFO write occurs at edge k+1. `wr_valid` is high after edge k+1 if the FIFO was empty.
- Throughput: one pixel per cycle sustained.
- Reset outputs: `wr_valid`=0, `wr_addr`=0, `wr_data`=0, `ovf_cnt`=0, `field_start`=0.
- Reset clears all counters, lane, field, and FIFO pointers. A reset mid-word or mid-field discards everything. The first `pix_sof` after reset starts clean.
- Pixels arriving before the first `pix_sof` after reset are ignored.

## Configuration
- `NTSC_CROP_EN` defined:
  - Pixels with x < `COL_START` or y < `ROW_START` are dropped.
  - Address and limits use x-`COL_START` and y-`ROW_START`.
- `NTSC_CROP_EN` undefined:
  - No crop.
  - `COL_START`/`ROW_START` are ignored; no logic is generated for them.

## Structure
- Package `ntsc_zbt_pkg`:
  - Default widths.
  - Constant `XW_BITS = ADDR_W-Y_BITS-1`.
  - Address-packing function.
  - Saturating-increment helper.
- Sub-module `ntsc_word_fifo`:
  - Synchronous FIFO, width `ADDR_W+MEM_W`, depth `FIFO_DEPTH`.
  - Registered outputs and full/empty flags.

## Test plan
- Defaults; sof with field=0, then 4 valid pixels A,B,C,D with ready=1 → two writes: addr 0 data {A,B}, then addr 1 data {C,D}. First write has `wr_valid` high 2 edges after pixel A's sibling B.
- sof field=1, sol, then 3 pixels P,Q,R → writes at addr {y=1,f=1,xw=0} = 0x600 data {P,Q}, then the partial {R,0} at 0x601 on the next sol.
- `wr_ready`=0, 6 complete words streamed → 4 are buffered, `ovf_cnt`=2. Ready raised → exactly 4 writes, in order.
- 1100-pixel line → last word written has xw=511. No write carries xw≥512.
- Reset asserted between pixel A and B of a word → no write. After a fresh sof, the first write is at addr 0.
- `NTSC_CROP_EN`, `COL_START`=30 → pixel x=30 appears at lane 0 of addr 0. Pixels x<30 are never written.
